freq_meter: RTL
===============

# freq_meter

Gated frequency meter that consumes one of the divided clocks produced by the clock/frequency-divider chain. It treats that clock as a data input, synchronises it into the master clock domain and counts its rising edges over a fixed window of master-clock cycles. It reports the count with a one-cycle valid strobe. It is the measurement stage directly downstream of the divider outputs, used to check divider ratios in hardware.

## Interface
Parameters:
- GATE_CYCLES, 1000, length of the measurement window in in_clk cycles (≥2)
- CNT_W, 16, width of the edge counter and of count_out

Ports:
- in_clk  input  1  master clock; the only clock in the block
- in_rst  input  1  reset, synchronous, active-high
- sig_in  input  1  signal under measurement (a divided clock), asynchronous to in_clk
- enable  input  1  measurement enable, level-sensitive
- count_out  output  CNT_W  rising edges of sig_in counted in the last completed window
- count_valid  output  1  one-cycle pulse when count_out updates
- busy  output  1  high whenever state ≠ IDLE
- count_ovf  output  1  overflow flag for the last window; exists only when FREQ_METER_OVF_EN is defined

## Operation
- Input path: 2-flop synchroniser (s1, s2), then history flop s3. edge_det = s2 & ~s3.
- Gate timer: counts 0..GATE_CYCLES-1, width clog2(GATE_CYCLES). Edge counter: CNT_W bits.
- FSM states: IDLE, ARM, GATE.
  - IDLE: transitions to ARM when enable=1.
  - ARM: lasts one cycle; clears the gate timer and the edge counter; transitions to GATE.
  - GATE: the timer increments every cycle; the edge counter increments on each edge_det.
    - enable=0 in any GATE cycle: abort to IDLE. No valid strobe; count_out and count_ovf hold.
    - Timer = GATE_CYCLES-1 and enable=1: the edge_det of this final cycle is included. Load count_out with that total, pulse count_valid, go to ARM.
- Continuous mode: with enable held high, one result is produced every GATE_CYCLES+1 cycles (ARM + GATE).
- Edges seen during ARM and IDLE are discarded.
- Reset (in_rst=1 at a clock edge, including mid-window) sets all of the following to 0: state=IDLE, s1/s2/s3, timer, edge counter, count_out, count_valid, busy, count_ovf.

## Timing
- Reset values: count_out=0, count_valid=0, busy=0, count_ovf=0.
- A sig_in rising edge is reflected in the edge counter 3 in_clk edges after it is sampled (s1 → s2 → counter).
- Input constraint: sig_in high and low phases must each be ≥2 in_clk periods. Faster inputs undercount, with no error indication.
- enable rise sampled at edge N: busy=1 and state=ARM after edge N. The first GATE cycle follows edge N+1. count_valid is high for the cycle after edge N+1+GATE_CYCLES.
- count_valid is exactly one cycle wide and is never asserted in consecutive cycles.
- busy falls one edge after enable is sampled low in GATE or ARM. ARM always completes into GATE; the abort happens there.
- Simultaneous final-cycle edge_det and window end: the edge is counted in the closing window.

## Configuration
- FREQ_METER_OVF_EN defined:
  - The edge counter saturates at 2^CNT_W-1.
  - The count_ovf port exists. It loads with count_out and is 1 if any edge arrived while the counter was already saturated.
- FREQ_METER_OVF_EN undefined:
  - The counter wraps modulo 2^CNT_W.
  - The count_ovf port and its logic are absent.

## Test plan
- Reset while sig_in toggles and enable=1, held 3 cycles → count_out=0, count_valid=0, busy=0 throughout; ARM begins the cycle after in_rst drops.
- GATE_CYCLES=1000, CNT_W=16, sig_in period 8 in_clk cycles, enable held → count_out=125 on every strobe; strobes 1001 cycles apart.
- sig_in held 0, enable held → count_out=0 with regular count_valid strobes; count_ovf=0.
- Previous result 125; enable dropped at GATE cycle 500 → no strobe, count_out stays 125, busy=0 one cycle later.
- CNT_W=4, GATE_CYCLES=100, sig_in period 4 (25 edges):
  - macro defined → count_out=15, count_ovf=1
  - macro undefined → count_out=9
- Reset asserted at GATE cycle 300 of a window, enable still high → outputs 0; after release ARM, then a full window, then count_out=125 (period-8 input).

Source files
------------

// File: rtl/freq_meter_if.sv
// freq_meter_if: measurement-side bundle of the gated frequency meter.
//   sig_in      signal under measurement (asynchronous to the master clock)
//   enable      level-sensitive measurement enable
//   count_out   rising edges counted in the last completed window
//   count_valid one-cycle strobe when count_out updates
//   busy        meter is arming or gating
//   count_ovf   saturation flag of the last window (only with FREQ_METER_OVF_EN)
// master = stimulus/consumer side, slave = the meter.
interface freq_meter_if #(
    parameter int CNT_W = 16
) ();
    logic             sig_in;
    logic             enable;
    logic [CNT_W-1:0] count_out;
    logic             count_valid;
    logic             busy;
`ifdef FREQ_METER_OVF_EN
    logic             count_ovf;
    modport master (output sig_in, enable, input count_out, count_valid, busy, count_ovf);
    modport slave  (input sig_in, enable, output count_out, count_valid, busy, count_ovf);
`else
    modport master (output sig_in, enable, input count_out, count_valid, busy);
    modport slave  (input sig_in, enable, output count_out, count_valid, busy);
`endif
endinterface

// File: rtl/freq_meter.sv
// freq_meter: gated frequency meter counting rising edges of sig_in over
// GATE_CYCLES master-clock cycles and reporting the total with a strobe.
//   in_clk  master clock (the only clock)
//   in_rst  synchronous active-high reset
//   m       freq_meter_if.slave: sig_in, enable in; count_out, count_valid,
//           busy (and count_ovf) out
// Optional feature macro FREQ_METER_OVF_EN: saturating counter plus count_ovf;
// without it the counter wraps and count_ovf is absent.
module freq_meter #(
    parameter int GATE_CYCLES = 1000,
    parameter int CNT_W       = 16
) (
    input  logic          in_clk,
    input  logic          in_rst,
    freq_meter_if.slave   m
);
    localparam int               TW     = $clog2(GATE_CYCLES);
    localparam logic [TW-1:0]    T_LAST = TW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_MAX  = '1;

    typedef enum logic [1:0] {IDLE, ARM, GATE} state_t;

    state_t           state_q, state_d;
    logic             s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, total;
    logic [CNT_W-1:0] count_out_q, count_out_d;
    logic             count_valid_q, count_valid_d;
    logic             edge_det, done, busy;

    always_ff @(posedge in_clk) begin
        if (in_rst) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // ARM is never aborted; only GATE reacts to enable dropping.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = m.enable ? ARM : IDLE;
            ARM:     state_d = GATE;
            GATE:    state_d = !m.enable ? IDLE : (timer_q == T_LAST) ? ARM : GATE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = state_q != IDLE;
    end

    always_comb begin
        s1_d     = m.sig_in;
        s2_d     = s1_q;
        s3_d     = s2_q;
        edge_det = s2_q & ~s3_q;
        done     = state_q == GATE && m.enable && timer_q == T_LAST;
`ifdef FREQ_METER_OVF_EN
        total    = (edge_det && cnt_q != C_MAX) ? cnt_q + CNT_W'(1) : cnt_q;
`else
        total    = cnt_q + CNT_W'(edge_det);
`endif
        timer_d       = state_q == ARM ? '0 : state_q == GATE ? timer_q + TW'(1) : timer_q;
        cnt_d         = state_q == ARM ? '0 : state_q == GATE ? total : cnt_q;
        // total already includes the final cycle's edge
        count_out_d   = done ? total : count_out_q;
        count_valid_d = done;
    end

`ifdef FREQ_METER_OVF_EN
    logic ovf_acc_q, ovf_acc_d, count_ovf_q, count_ovf_d;

    always_comb begin
        ovf_acc_d   = state_q == ARM ? 1'b0 :
                      state_q == GATE ? ovf_acc_q | (edge_det && cnt_q == C_MAX) : ovf_acc_q;
        count_ovf_d = done ? ovf_acc_d : count_ovf_q;
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            ovf_acc_q   <= 1'b0;
            count_ovf_q <= 1'b0;
        end else begin
            ovf_acc_q   <= ovf_acc_d;
            count_ovf_q <= count_ovf_d;
        end
    end

    assign m.count_ovf = count_ovf_q;
`endif

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            s1_q          <= 1'b0;
            s2_q          <= 1'b0;
            s3_q          <= 1'b0;
            timer_q       <= '0;
            cnt_q         <= '0;
            count_out_q   <= '0;
            count_valid_q <= 1'b0;
        end else begin
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            s3_q          <= s3_d;
            timer_q       <= timer_d;
            cnt_q         <= cnt_d;
            count_out_q   <= count_out_d;
            count_valid_q <= count_valid_d;
        end
    end

    assign m.count_out   = count_out_q;
    assign m.count_valid = count_valid_q;
    assign m.busy        = busy;
endmodule
